game_ctrl: RTL
==============

Name: game_ctrl

Overview:
- Parametrised Minesweeper game-flow controller for an arbitrary ROWS x COLS board with MINES mines.
- Sequences start, first-cell selection, mine placement and play, then win/lose, play-again and board clear.
- Adds over the previous controller: on-chip win detection by counting remaining safe cells, an optional time limit, handshakes to the mine placer and board-clear logic, and a win tally.
- Sits between the input/debounce logic and the board datapath (mine placer, reveal engine, display).

Parameters:
- ROWS, 8, board rows (2..32).
- COLS, 8, board columns (2..32).
- MINES, 10, mine count (1..ROWS*COLS-1).
- TIME_LIMIT, 999, seconds allowed in PLAY; 0 means no limit.
- TW, 10, width of the seconds counter; must hold TIME_LIMIT.
- Local: CW = clog2(ROWS*COLS+1), width of the safe-cell counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- go  in  1  start request; sampled only in IDLE
- sel  in  1  first-cell selected pulse; sampled only in WAIT_SEL
- place_done  in  1  mine placer finished; sampled only in PLACE
- reveal_safe  in  1  one newly revealed safe cell this cycle; sampled only in PLAY
- reveal_mine  in  1  a mine was revealed this cycle; sampled only in PLAY
- tick  in  1  1 Hz single-cycle enable
- play_again  in  1  restart request; sampled only in AGAIN
- clr_done  in  1  board clear finished; sampled only in CLEAR
- place_start  out  1  one-cycle pulse requesting mine placement
- clr_start  out  1  one-cycle pulse requesting board clear
- state  out  3  current state encoding
- safe_left  out  CW  safe cells still hidden
- time_sec  out  TW  elapsed seconds of the current game
- win  out  1  last game won
- lose  out  1  last game lost
- done  out  1  game over
- win_count  out  8  games won since reset, saturating at 255

Behaviour:
- Clock is clk; reset rst is asynchronous and active-low.
- Reset drives: state=IDLE; all outputs 0, except safe_left=ROWS*COLS-MINES.
- All outputs are registered, including the place_start and clr_start pulses.
- States and encodings: IDLE=0, WAIT_SEL=1, PLACE=2, PLAY=3, WIN=4, LOSE=5, AGAIN=6, CLEAR=7. There are no unused codes.
- IDLE -> WAIT_SEL when go=1.
- WAIT_SEL -> PLACE when sel=1.
  - On this transition: load safe_left=ROWS*COLS-MINES; assert place_start for exactly one cycle, coincident with the first PLACE cycle.
- PLACE waits for place_done, then -> PLAY.
  - On this transition: clear time_sec to 0.
  - place_done in the same cycle as the place_start pulse is accepted.
- PLAY priority, highest first:
  1. reveal_mine=1 -> LOSE.
  2. Timeout -> LOSE. Timeout means TIME_LIMIT!=0, tick=1 and time_sec==TIME_LIMIT-1.
  3. reveal_safe=1 and safe_left==1 -> safe_left becomes 0, then WIN.
  4. Otherwise reveal_safe decrements safe_left, saturating at 0; a decrement at 0 is ignored.
  - reveal_mine together with reveal_safe on the last safe cell -> LOSE; safe_left is not decremented.
  - time_sec increments on tick only in PLAY and saturates at 2^TW-1 when TIME_LIMIT=0.
  - On the timeout cycle time_sec becomes TIME_LIMIT.
  - time_sec is frozen in every other state.
- WIN (one cycle):
  - Set win=1 and lose=0.
  - Increment win_count, saturating at 255.
  - Then -> AGAIN.
- LOSE (one cycle): set lose=1 and win=0, then -> AGAIN.
- done=1 in WIN, LOSE and AGAIN; 0 elsewhere.
- AGAIN waits for play_again=1, then -> CLEAR.
  - On this transition: assert clr_start for one cycle.
- CLEAR waits for clr_done, then -> WAIT_SEL.
  - On this transition: clear win and lose.
  - time_sec and safe_left keep their values until reloaded.
- Inputs outside their sampling state are ignored, e.g. go during PLAY or sel during PLACE.
- Reset mid-operation, e.g. during PLACE, aborts to IDLE within the same cycle (asynchronous). Any pending handshake is dropped. win_count returns to 0.
- Level inputs held high are treated as repeated requests. A held sel therefore advances WAIT_SEL -> PLACE immediately after CLEAR.

Test Plan:
- ROWS=4, COLS=4, MINES=3; go, sel, place_done 2 cycles later, then 13 reveal_safe pulses -> safe_left counts 13..0; state WIN for one cycle, then AGAIN; win=1, done=1, win_count=1.
- Same setup; 5 reveal_safe pulses then reveal_mine -> safe_left=8; LOSE then AGAIN; lose=1, win=0, win_count unchanged.
- TIME_LIMIT=3; in PLAY issue 3 tick pulses with no reveals -> time_sec=1,2,3; LOSE on the 3rd tick. With TIME_LIMIT=0 and 1100 ticks, TW=10 -> time_sec saturates at 1023 and stays in PLAY.
- safe_left=1 with reveal_safe and reveal_mine in the same cycle -> LOSE, safe_left stays 1. Issue go and sel during PLAY -> no state change.
- In AGAIN assert play_again -> one-cycle clr_start, CLEAR; assert clr_done 4 cycles later -> WAIT_SEL, win=lose=0. Then sel -> place_start pulse, safe_left=13.
- Assert rst low during PLACE (asynchronously, mid-cycle) -> state=0 immediately, all outputs 0, safe_left=13. Win 256 games -> win_count saturates at 255.

Source files
------------

// File: rtl/game_ctrl.sv
// Minesweeper game-flow controller: start, first-cell select, mine placement,
// play with safe-cell countdown and optional time limit, win/lose and board clear.
module game_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int MINES      = 10,
    parameter int TIME_LIMIT = 999,
    parameter int TW         = 10,
    localparam int CW        = $clog2(ROWS*COLS+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          sel,
    input  logic          place_done,
    input  logic          reveal_safe,
    input  logic          reveal_mine,
    input  logic          tick,
    input  logic          play_again,
    input  logic          clr_done,
    output logic          place_start,
    output logic          clr_start,
    output logic [2:0]    state,
    output logic [CW-1:0] safe_left,
    output logic [TW-1:0] time_sec,
    output logic          win,
    output logic          lose,
    output logic          done,
    output logic [7:0]    win_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SEL = 3'd1,
        PLACE    = 3'd2,
        PLAY     = 3'd3,
        WIN      = 3'd4,
        LOSE     = 3'd5,
        AGAIN    = 3'd6,
        CLEAR    = 3'd7
    } state_t;

    localparam logic [CW-1:0] SAFE_CELLS = CW'(ROWS*COLS-MINES);
    localparam logic [TW-1:0] TIME_MAX   = '1;
    localparam logic [TW-1:0] TIME_LIM   = TW'(TIME_LIMIT);
    localparam logic [TW-1:0] TIME_LAST  = TW'(TIME_LIMIT-1);

    state_t        r_state;
    logic [CW-1:0] r_safe;
    logic [TW-1:0] r_time;
    logic          r_place;
    logic          r_clr;
    logic          r_win;
    logic          r_lose;
    logic          r_done;
    logic [7:0]    r_wins;
    logic          w_timeout;

    assign w_timeout = (TIME_LIMIT != 0) && tick && (r_time == TIME_LAST);

    // Outputs are set on entry to a state so they line up with the state code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_safe  <= SAFE_CELLS;
            r_time  <= '0;
            r_place <= 1'b0;
            r_clr   <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
            r_done  <= 1'b0;
            r_wins  <= 8'd0;
        end else begin
            r_place <= 1'b0;
            r_clr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (go) r_state <= WAIT_SEL;
                end
                WAIT_SEL: begin
                    if (sel) begin
                        r_state <= PLACE;
                        r_safe  <= SAFE_CELLS;
                        r_place <= 1'b1;
                    end
                end
                PLACE: begin
                    if (place_done) begin
                        r_state <= PLAY;
                        r_time  <= '0;
                    end
                end
                PLAY: begin
                    if (w_timeout) begin
                        r_time <= TIME_LIM;
                    end else if (tick && r_time != TIME_MAX) begin
                        r_time <= r_time + TW'(1);
                    end
                    if (reveal_mine || w_timeout) begin
                        r_state <= LOSE;
                        r_lose  <= 1'b1;
                        r_win   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (reveal_safe && r_safe == CW'(1)) begin
                        r_safe  <= '0;
                        r_state <= WIN;
                        r_win   <= 1'b1;
                        r_lose  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_wins != 8'd255) r_wins <= r_wins + 8'd1;
                    end else if (reveal_safe && r_safe != '0) begin
                        r_safe <= r_safe - CW'(1);
                    end
                end
                WIN, LOSE: begin
                    r_state <= AGAIN;
                end
                AGAIN: begin
                    if (play_again) begin
                        r_state <= CLEAR;
                        r_clr   <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_done) begin
                        r_state <= WAIT_SEL;
                        r_win   <= 1'b0;
                        r_lose  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign state       = r_state;
    assign safe_left   = r_safe;
    assign time_sec    = r_time;
    assign place_start = r_place;
    assign clr_start   = r_clr;
    assign win         = r_win;
    assign lose        = r_lose;
    assign done        = r_done;
    assign win_count   = r_wins;

endmodule
